// File: rtl/snitch_shared_acc_arbiter.sv
// Round-robin arbiter sharing one offloaded accelerator port between cluster cores.
// Granted core indices are queued in an in-order tag FIFO to steer responses back.
module snitch_shared_acc_arbiter #(
  parameter int unsigned NrCores        = 4,
  parameter int unsigned ReqWidth       = 96,
  parameter int unsigned RspWidth       = 37,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned IdxW          = $clog2(NrCores),
  localparam int unsigned CntW          = $clog2(MaxOutstanding + 1)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NrCores-1:0]                core_en_i,
  input  logic [NrCores-1:0]                req_valid_i,
  output logic [NrCores-1:0]                req_ready_o,
  input  logic [NrCores-1:0][ReqWidth-1:0]  req_data_i,
  output logic                              acc_req_valid_o,
  input  logic                              acc_req_ready_i,
  output logic [ReqWidth-1:0]               acc_req_data_o,
  input  logic                              acc_rsp_valid_i,
  output logic                              acc_rsp_ready_o,
  input  logic [RspWidth-1:0]               acc_rsp_data_i,
  output logic [NrCores-1:0]                rsp_valid_o,
  input  logic [NrCores-1:0]                rsp_ready_i,
  output logic [RspWidth-1:0]               rsp_data_o,
  output logic [CntW-1:0]                   outstanding_o,
  output logic                              err_o
);

  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  logic [IdxW-1:0] prio_q, prio_d;
  logic            lock_q, lock_d;
  logic [IdxW-1:0] locked_idx_q, locked_idx_d;
  logic [IdxW-1:0] tag_q [MaxOutstanding];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  logic [NrCores-1:0] eligible;
  logic               gnt_valid;
  logic [IdxW-1:0]    gnt_idx;
  logic [IdxW-1:0]    head_idx;
  logic               empty, full, push, pop, spurious;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CntW'(MaxOutstanding));
  assign eligible = full ? '0 : (req_valid_i & core_en_i);
  assign head_idx = tag_q[rd_ptr_q];

  // Grant: locked core wins, otherwise first eligible index at or after prio_q.
  always_comb begin
    int unsigned cand;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    if (lock_q) begin
      gnt_valid = 1'b1;
      gnt_idx   = locked_idx_q;
    end else begin
      for (int unsigned i = 0; i < NrCores; i++) begin
        cand = 32'(prio_q) + i;
        if (cand >= NrCores) cand = cand - NrCores;
        if (!gnt_valid && eligible[IdxW'(cand)]) begin
          gnt_valid = 1'b1;
          gnt_idx   = IdxW'(cand);
        end
      end
    end
  end

  assign acc_req_valid_o = gnt_valid;
  assign acc_req_data_o  = req_data_i[gnt_idx];
  assign push            = gnt_valid & acc_req_ready_i;

  always_comb begin
    req_ready_o = '0;
    if (gnt_valid) req_ready_o[gnt_idx] = acc_req_ready_i;
  end

  // Response steering to the core at the FIFO head; with no owner the response is sunk.
  always_comb begin
    rsp_valid_o     = '0;
    acc_rsp_ready_o = 1'b1;
    if (!empty) begin
      rsp_valid_o[head_idx] = acc_rsp_valid_i;
      acc_rsp_ready_o       = rsp_ready_i[head_idx];
    end
  end

  assign pop        = !empty & acc_rsp_valid_i & rsp_ready_i[head_idx];
  assign spurious   = empty & acc_rsp_valid_i;
  assign rsp_data_o = acc_rsp_data_i;

  always_comb begin
    prio_d       = prio_q;
    lock_d       = lock_q;
    locked_idx_d = locked_idx_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    err_d        = err_q | spurious;
    if (push) begin
      lock_d   = 1'b0;
      prio_d   = (gnt_idx == IdxW'(NrCores - 1)) ? '0 : gnt_idx + 1'b1;
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else if (gnt_valid) begin
      lock_d       = 1'b1;
      locked_idx_d = gnt_idx;
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q       <= '0;
      lock_q       <= 1'b0;
      locked_idx_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      for (int unsigned i = 0; i < MaxOutstanding; i++) tag_q[i] <= '0;
    end else begin
      prio_q       <= prio_d;
      lock_q       <= lock_d;
      locked_idx_q <= locked_idx_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      if (push) tag_q[wr_ptr_q] <= gnt_idx;
    end
  end

  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_snitch_shared_acc_arbiter.sv
// Randomized bench for snitch_shared_acc_arbiter against a queue-based reference model.
module tb_snitch_shared_acc_arbiter;
  localparam int N    = 4;
  localparam int RQW  = 96;
  localparam int RSW  = 37;
  localparam int MAXO = 4;
  localparam int CW   = $clog2(MAXO + 1);

  logic                    clk = 1'b0;
  logic                    rst_ni;
  logic [N-1:0]            core_en;
  logic [N-1:0]            req_valid;
  logic [N-1:0]            req_ready;
  logic [N-1:0][RQW-1:0]   req_data;
  logic                    acc_req_valid;
  logic                    acc_req_ready;
  logic [RQW-1:0]          acc_req_data;
  logic                    acc_rsp_valid;
  logic                    acc_rsp_ready;
  logic [RSW-1:0]          acc_rsp_data;
  logic [N-1:0]            rsp_valid;
  logic [N-1:0]            rsp_ready;
  logic [RSW-1:0]          rsp_data;
  logic [CW-1:0]           outstanding;
  logic                    err;

  snitch_shared_acc_arbiter #(
    .NrCores(N), .ReqWidth(RQW), .RspWidth(RSW), .MaxOutstanding(MAXO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .core_en_i(core_en),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data),
    .acc_req_valid_o(acc_req_valid), .acc_req_ready_i(acc_req_ready),
    .acc_req_data_o(acc_req_data),
    .acc_rsp_valid_i(acc_rsp_valid), .acc_rsp_ready_o(acc_rsp_ready),
    .acc_rsp_data_i(acc_rsp_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .outstanding_o(outstanding), .err_o(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: issue-order queue of core ids, rotating priority, held grant.
  int q[$];
  int prio    = 0;
  int locked  = -1;
  bit err_m   = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    prio   = 0;
    locked = -1;
    err_m  = 1'b0;
  endtask

  // Inputs are driven at the falling edge; this checks outputs, then advances the model.
  task automatic step();
    int           g;
    logic [N-1:0] e_rdy, e_rsp;
    logic         e_acc_rsp_rdy;
    bit           push, pop, spur;
    #1;
    g = -1;
    if (locked >= 0) g = locked;
    else if (q.size() < MAXO) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (prio + k) % N;
        if (req_valid[c] && core_en[c]) begin
          g = c;
          break;
        end
      end
    end
    e_rdy = '0;
    if (g >= 0) e_rdy[g] = acc_req_ready;
    e_rsp = '0;
    e_acc_rsp_rdy = 1'b1;
    pop  = 1'b0;
    spur = 1'b0;
    if (q.size() > 0) begin
      e_rsp[q[0]]   = acc_rsp_valid;
      e_acc_rsp_rdy = rsp_ready[q[0]];
      pop           = acc_rsp_valid && rsp_ready[q[0]];
    end else begin
      spur = acc_rsp_valid;
    end
    check("acc_req_valid", 128'(acc_req_valid), 128'(g >= 0));
    check("req_ready", 128'(req_ready), 128'(e_rdy));
    if (g >= 0) check("acc_req_data", 128'(acc_req_data), 128'(req_data[g]));
    check("acc_rsp_ready", 128'(acc_rsp_ready), 128'(e_acc_rsp_rdy));
    check("rsp_valid", 128'(rsp_valid), 128'(e_rsp));
    check("rsp_data", 128'(rsp_data), 128'(acc_rsp_data));
    check("outstanding", 128'(outstanding), 128'(q.size()));
    check("err", 128'(err), 128'(err_m));
    push = (g >= 0) && acc_req_ready;
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (push) begin
      q.push_back(g);
      prio   = (g + 1) % N;
      locked = -1;
    end else if (g >= 0) begin
      locked = g;
    end
    if (spur) err_m = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    core_en       = '1;
    req_valid     = '0;
    acc_req_ready = 1'b0;
    acc_rsp_valid = 1'b0;
    rsp_ready     = '0;
    acc_rsp_data  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni = 1'b0;
    model_reset();
    #1;
    check("rst_outstanding", 128'(outstanding), 128'(0));
    check("rst_err", 128'(err), 128'(0));
    check("rst_acc_req_valid", 128'(acc_req_valid), 128'(0));
    check("rst_req_ready", 128'(req_ready), 128'(0));
    check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    check("rst_acc_rsp_ready", 128'(acc_rsp_ready), 128'(1));
    @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic rand_data(input int c);
    req_data[c] = {$urandom, $urandom, $urandom};
  endtask

  initial begin
    for (int c = 0; c < N; c++) rand_data(c);
    @(negedge clk);
    do_reset();

    // Directed lock: core 2 held for three cycles while core 1 also requests.
    req_valid = 4'b0100;
    rsp_ready = '1;
    step();
    req_valid = 4'b0110;
    step();
    step();
    acc_req_ready = 1'b1;
    step();
    step();
    req_valid = '0;
    acc_rsp_valid = 1'b1;
    for (int i = 0; i < 8; i++) step();

    // Spurious response after a clean reset.
    do_reset();
    acc_rsp_valid = 1'b1;
    acc_rsp_data  = RSW'($urandom);
    step();
    acc_rsp_valid = 1'b0;
    step();
    check("err_sticky", 128'(err), 128'(1));

    // Randomized traffic with one mid-run reset.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc == 1000) begin
        do_reset();
        continue;
      end
      for (int c = 0; c < N; c++) begin
        if (c == locked) begin
          req_valid[c] = 1'b1;
        end else begin
          req_valid[c] = ($urandom_range(0, 9) < 6);
          rand_data(c);
        end
        core_en[c]   = ($urandom_range(0, 19) < 17);
        rsp_ready[c] = ($urandom_range(0, 3) != 0);
      end
      acc_req_ready = ($urandom_range(0, 9) < 6);
      if (q.size() > 0) acc_rsp_valid = ($urandom_range(0, 1) == 1);
      else              acc_rsp_valid = ($urandom_range(0, 99) == 0);
      acc_rsp_data = RSW'({$urandom, $urandom});
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule
